// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: consumes the FIFO rx_rdy/rx_done handshake and shifts each word out as a UART frame.
// States IDLE->ACK->START->DATA->[PARITY]->STOP; define FIFO_UART_TX_PARITY_EN to add an even-parity bit.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             rx_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             rx_done,
    output logic             tx,
    output logic             busy,
    output logic [15:0]      frame_count
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACK    = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif
    localparam logic [2:0] S_STOP   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             rx_done_q, rx_done_d;
    logic             busy_q, busy_d;
    logic [15:0]      cnt_q, cnt_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        rx_done_d = rx_done_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en && rx_rdy) begin
                    shift_d   = in_data;
`ifdef FIFO_UART_TX_PARITY_EN
                    par_d     = ^in_data;
`endif
                    rx_done_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                if (!rx_rdy) begin
                    rx_done_d = 1'b0;
                    tx_d      = 1'b0;
                    baud_d    = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    cnt_d   = cnt_q + 16'd1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    // Back-to-back capture saves the idle cycle between frames
                    if (en && rx_rdy) begin
                        shift_d   = in_data;
`ifdef FIFO_UART_TX_PARITY_EN
                        par_d     = ^in_data;
`endif
                        rx_done_d = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = S_ACK;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            rx_done_q <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rx_done_q <= rx_done_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx          = tx_q;
    assign rx_done     = rx_done_q;
    assign busy        = busy_q;
    assign frame_count = cnt_q;
endmodule
